riscv16_mc_ctrl: RTL
====================

# riscv16_mc_ctrl

Multi-cycle control unit for the 16-bit RISC core. It sequences one shared ALU, register file, instruction memory and data memory through fetch, decode, execute, memory and writeback. It drives the 3-bit ALU select using the ALU's own encoding and consumes the ALU zero flag for branches. It sits between the memories and the datapath muxes, holds its own copy of the current instruction, and counts retired instructions.

## Interface
- No parameters; the encoding is fixed.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  start request, sampled in IDLE
- instr  in  16  instruction word from instruction memory
- instr_valid  in  1  instruction memory handshake: instr is valid this cycle
- dmem_ready  in  1  data memory handshake: access completes this cycle
- zf  in  1  ALU zero flag
- imem_re  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC write enable
- pc_src  out  2  PC source: 00 = PC+2, 01 = PC+2·sext(imm6), 10 = PC+2·sext(imm9)
- alu_sel  out  3  ALU select: 000 add, 001 sub, 010 sll, 011 srl, 100 sar, 101 nand, 110 or
- alu_src_b  out  2  ALU B source: 00 = rs2, 01 = sext(imm6)
- rf_we  out  1  register file write enable
- wb_sel  out  2  writeback source: 00 = ALU, 01 = data memory, 10 = PC
- dmem_re, dmem_we  out  1  data memory read / write request
- halted  out  1  HALT executed
- illegal  out  1  illegal opcode trapped
- state  out  3  current FSM state, for debug
- retired  out  16  retired-instruction count

## Operation
- Instruction fields:
  - op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3]
  - imm6 = [5:0], imm9 = [8:0], both sign-extended
- Opcodes:
  - 0000–0110: R-type; alu_sel = op[2:0]
  - 0111: ADDI
  - 1000: LW, address rs1+imm6
  - 1001: SW
  - 1010: BEQ rs1, rs2, imm6
  - 1011: JAL rd, imm9
  - 1111: HALT
  - all others: illegal
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6, TRAP = 7.
- IDLE: all strobes 0. When run = 1, go to FETCH.
- FETCH: imem_re = 1 and held until instr_valid.
  - On the cycle instr_valid = 1: ir_we = 1, pc_we = 1, pc_src = 00, the internal IR latches instr, next state DECODE.
- DECODE: one cycle, no strobes.
  - HALT opcode → HALT state.
  - Illegal opcode → TRAP state.
  - Otherwise → EXEC.
- EXEC:
  - R-type: alu_src_b = 00, then WB.
  - ADDI, LW, SW: alu_sel = 000, alu_src_b = 01. ADDI → WB; LW/SW → MEM.
  - BEQ: alu_sel = 001, alu_src_b = 00. If zf = 1: pc_we = 1, pc_src = 01. Retire, then FETCH.
  - JAL: rf_we = 1, wb_sel = 10, pc_we = 1, pc_src = 10. Retire, then FETCH.
- MEM:
  - LW holds dmem_re = 1, SW holds dmem_we = 1, with alu_sel/alu_src_b held as in EXEC.
  - On dmem_ready: LW → WB; SW retires, then FETCH.
- WB: rf_we = 1. wb_sel = 01 for LW, 00 otherwise; alu_sel/alu_src_b held as in EXEC. Retire, then FETCH.
- HALT: halted = 1. TRAP: illegal = 1. Both are terminal until rst; run is ignored.
- retired increments by 1 on each retire cycle and wraps FFFF → 0000. HALT and illegal instructions do not count.
- All strobes are Moore outputs decoded from state + IR, except the FETCH strobes (gated by instr_valid), the MEM completion (gated by dmem_ready) and the BEQ pc_we (gated by zf).

## Timing
- Reset (asynchronous): state = IDLE, IR = 0, retired = 0, and every output 0, immediately and without waiting for clk. Reset asserted mid-instruction abandons it with no partial write.
- Latency with zero-wait memories:
  - R-type, ADDI: 4 cycles
  - BEQ, JAL: 3 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - Each memory wait cycle adds 1.
- instr_valid outside FETCH and dmem_ready outside MEM are ignored.
- At most one of rf_we, dmem_we, and ir_we is asserted per cycle.
- zf is sampled only in EXEC for BEQ.

## Test plan
- R-type ADD (0x0298), zero-wait memory, run pulsed from IDLE → states 1,2,3,5; rf_we only in the WB cycle; retired 0 → 1.
- LW with dmem_ready delayed 3 cycles → dmem_re held for 4 cycles, then WB with wb_sel = 01; total latency 8 cycles.
- BEQ run twice, once with zf = 1 and once with zf = 0 → pc_we/pc_src = 01 in EXEC only when zf = 1; no rf_we in either case.
- JAL → single EXEC cycle with rf_we = 1, wb_sel = 10, pc_src = 10; the next state is FETCH.
- Opcode 0xC000 → TRAP with illegal = 1; opcode 0xF000 → HALT with halted = 1. Both ignore run and do not increment retired.
- rst asserted mid-MEM with dmem_we = 1 → all outputs 0 before the next clk edge; retired preset to FFFF (via force) wraps to 0000 on the next retire.

Source files
------------

// File: rtl/riscv16_mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: sequences fetch, decode,
// execute, memory and writeback over a shared ALU, register file and memories.
module riscv16_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        dmem_ready,
  input  logic        zf,
  output logic        imem_re,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_sel,
  output logic [1:0]  alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_HALT = 3'd6,
    CLS_ILL  = 3'd7
  } op_class_t;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [1:0] SRC_RS2 = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] ir_r;
  logic [15:0] retired_r;
  op_class_t   cls_s;
  logic        retire_s;
  logic [2:0]  alu_sel_s;
  logic [1:0]  alu_src_b_s;
  logic        unused_ir_s;

  function automatic op_class_t decode_op(input logic [3:0] op);
    op_class_t cls;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: cls = CLS_R;
      4'h7:    cls = CLS_ADDI;
      4'h8:    cls = CLS_LW;
      4'h9:    cls = CLS_SW;
      4'hA:    cls = CLS_BEQ;
      4'hB:    cls = CLS_JAL;
      4'hF:    cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // Register fields other than the opcode are carried for the datapath, not decoded here.
  assign cls_s       = decode_op(ir_r[15:12]);
  assign unused_ir_s = ^ir_r[11:0];
  assign state       = state_r;
  assign retired     = retired_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Private instruction register, loaded on the fetch handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_r <= 16'h0000;
    end else if (ir_we) begin
      ir_r <= instr;
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= 16'h0000;
    end else if (retire_s) begin
      retired_r <= retired_r + 16'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) next_state_s = ST_FETCH;
        else     next_state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (instr_valid) next_state_s = ST_DECODE;
        else             next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_HALT: next_state_s = ST_HALT;
          CLS_ILL:  next_state_s = ST_TRAP;
          default:  next_state_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_R, CLS_ADDI:  next_state_s = ST_WB;
          CLS_LW, CLS_SW:   next_state_s = ST_MEM;
          CLS_BEQ, CLS_JAL: next_state_s = ST_FETCH;
          default:          next_state_s = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (!dmem_ready)          next_state_s = ST_MEM;
        else if (cls_s == CLS_LW) next_state_s = ST_WB;
        else                      next_state_s = ST_FETCH;
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      ST_TRAP: next_state_s = ST_TRAP;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // ALU operation for the instruction in IR, held from EXEC through WB.
  always_comb begin
    alu_sel_s   = ALU_ADD;
    alu_src_b_s = SRC_RS2;
    case (cls_s)
      CLS_R: begin
        alu_sel_s   = ir_r[14:12];
        alu_src_b_s = SRC_RS2;
      end
      CLS_ADDI, CLS_LW, CLS_SW: begin
        alu_sel_s   = ALU_ADD;
        alu_src_b_s = SRC_IMM;
      end
      CLS_BEQ: begin
        alu_sel_s   = ALU_SUB;
        alu_src_b_s = SRC_RS2;
      end
      default: begin
        alu_sel_s   = ALU_ADD;
        alu_src_b_s = SRC_RS2;
      end
    endcase
  end

  // Retire pulse: last cycle of every completed non-HALT instruction.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      ST_EXEC: retire_s = (cls_s == CLS_BEQ) || (cls_s == CLS_JAL);
      ST_MEM:  retire_s = dmem_ready && (cls_s == CLS_SW);
      ST_WB:   retire_s = 1'b1;
      default: retire_s = 1'b0;
    endcase
  end

  // Output decode from state and IR; only handshakes and zf gate strobes.
  always_comb begin
    imem_re   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    alu_sel   = ALU_ADD;
    alu_src_b = SRC_RS2;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_re = 1'b1;
        if (instr_valid) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = PC_SEQ;
        end else begin
          ir_we  = 1'b0;
          pc_we  = 1'b0;
        end
      end
      ST_EXEC: begin
        alu_sel   = alu_sel_s;
        alu_src_b = alu_src_b_s;
        case (cls_s)
          CLS_BEQ: begin
            if (zf) begin
              pc_we  = 1'b1;
              pc_src = PC_BR;
            end else begin
              pc_we  = 1'b0;
              pc_src = PC_SEQ;
            end
          end
          CLS_JAL: begin
            rf_we  = 1'b1;
            wb_sel = WB_PC;
            pc_we  = 1'b1;
            pc_src = PC_JMP;
          end
          default: begin
            pc_we  = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        alu_sel   = alu_sel_s;
        alu_src_b = alu_src_b_s;
        if (cls_s == CLS_LW) begin
          dmem_re = 1'b1;
        end else if (cls_s == CLS_SW) begin
          dmem_we = 1'b1;
        end else begin
          dmem_re = 1'b0;
        end
      end
      ST_WB: begin
        alu_sel   = alu_sel_s;
        alu_src_b = alu_src_b_s;
        rf_we     = 1'b1;
        if (cls_s == CLS_LW) wb_sel = WB_MEM;
        else                 wb_sel = WB_ALU;
      end
      ST_HALT: halted  = 1'b1;
      ST_TRAP: illegal = 1'b1;
      default: begin
        imem_re = 1'b0;
      end
    endcase
  end

endmodule
